block_buffer_stage: RTL and testbench

- Block-granular elastic buffer between the word-to-block assembler and the block-oriented cipher/processing engine in cp2.
- Accepts BSIZE blocks from the assembler's block_ready/hold handshake and stores up to DEPTH blocks.
- Presents blocks first-word-fall-through to the engine with a valid/take handshake.
- Tags message boundaries by counting delivered blocks against a programmable message length.

---
 rtl/block_buffer_stage.sv | 92 +++++++++
 tb/tb_block_buffer_stage.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/block_buffer_stage.sv
// Block-granular elastic buffer between the word-to-block assembler and the
// block engine. It stores up to DEPTH blocks and presents the head block
// first-word-fall-through. Each head block is tagged as the last block of a
// message by counting delivered blocks against msg_blocks.
module block_buffer_stage #(
  parameter int BSIZE = 128,
  parameter int DEPTH = 4,
  parameter int CNTW  = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [BSIZE-1:0]         block_in,
  input  logic                     block_in_ready,
  output logic                     block_in_hold,
  input  logic                     flush,
  output logic [BSIZE-1:0]         block_out,
  output logic                     block_out_valid,
  input  logic                     block_out_take,
  output logic                     block_out_last,
  input  logic [CNTW-1:0]          msg_blocks,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     take_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [BSIZE-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CNTW-1:0]  msg_idx;
  logic             push;
  logic             pop;

  // Handshake decode and head-of-queue presentation from registered state
  always_comb begin
    block_in_hold   = (level == LW'(DEPTH));
    block_out_valid = (level != '0);
    push            = block_in_ready && !block_in_hold;
    pop             = block_out_take && block_out_valid;
    block_out       = block_out_valid ? mem[rd_ptr] : '0;
    // msg_blocks is non-zero whenever the subtraction is used, so it cannot wrap
    block_out_last  = block_out_valid && (msg_blocks != '0) &&
                      (msg_idx >= (msg_blocks - CNTW'(1)));
  end

  // Block storage; contents are not cleared by reset or flush
  always_ff @(posedge clock) begin
    if (push && !flush) begin
      mem[wr_ptr] <= block_in;
    end
  end

  // Pointers, occupancy, framing counter and sticky take error
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      msg_idx  <= '0;
      take_err <= 1'b0;
    end else begin
      if (block_out_take && !block_out_valid) begin
        take_err <= 1'b1;
      end
      if (flush) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        level   <= '0;
        msg_idx <= '0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + AW'(1);
        end
        if (pop) begin
          rd_ptr  <= rd_ptr + AW'(1);
          msg_idx <= block_out_last ? '0 : msg_idx + CNTW'(1);
        end
        if (push && !pop) begin
          level <= level + LW'(1);
        end else if (pop && !push) begin
          level <= level - LW'(1);
        end
      end
    end
  end

  // Occupancy never exceeds the number of entries
  level_bound: assert property (@(posedge clock) disable iff (reset)
    level <= LW'(DEPTH));

endmodule

// File: tb/tb_block_buffer_stage.sv
// Scoreboard bench for block_buffer_stage: accepted blocks are queued with
// their expected last flag, and a monitor compares every delivered block.
module tb_block_buffer_stage;
  localparam int BSIZE = 128;
  localparam int DEPTH = 4;
  localparam int CNTW  = 16;

  logic                   clock = 1'b0;
  logic                   reset;
  logic [BSIZE-1:0]       block_in;
  logic                   block_in_ready;
  logic                   block_in_hold;
  logic                   flush;
  logic [BSIZE-1:0]       block_out;
  logic                   block_out_valid;
  logic                   block_out_take;
  logic                   block_out_last;
  logic [CNTW-1:0]        msg_blocks;
  logic [$clog2(DEPTH):0] level;
  logic                   take_err;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [BSIZE-1:0] data;
    logic             last;
  } exp_t;
  exp_t sb[$];

  localparam logic [BSIZE-1:0] BLK_A = 128'hA000_0000_0000_0000_0000_0000_0000_000A;
  localparam logic [BSIZE-1:0] BLK_B = 128'hB000_0000_0000_0000_0000_0000_0000_000B;
  localparam logic [BSIZE-1:0] BLK_C = 128'hC000_0000_0000_0000_0000_0000_0000_000C;
  localparam logic [BSIZE-1:0] BLK_D = 128'hD000_0000_0000_0000_0000_0000_0000_000D;
  localparam logic [BSIZE-1:0] BLK_E = 128'hE000_0000_0000_0000_0000_0000_0000_000E;
  localparam logic [BSIZE-1:0] BLK_X = 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321;
  localparam logic [BSIZE-1:0] BLK_Y = 128'hFFFF_0000_FFFF_0000_FFFF_0000_FFFF_0000;

  block_buffer_stage #(.BSIZE(BSIZE), .DEPTH(DEPTH), .CNTW(CNTW)) dut (
    .clock          (clock),
    .reset          (reset),
    .block_in       (block_in),
    .block_in_ready (block_in_ready),
    .block_in_hold  (block_in_hold),
    .flush          (flush),
    .block_out      (block_out),
    .block_out_valid(block_out_valid),
    .block_out_take (block_out_take),
    .block_out_last (block_out_last),
    .msg_blocks     (msg_blocks),
    .level          (level),
    .take_err       (take_err)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [BSIZE-1:0] act,
                       input logic [BSIZE-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_block(input logic [BSIZE-1:0] d, input logic l);
    sb.push_back({d, l});
  endtask

  task automatic drain(input int n);
    block_out_take = 1'b1;
    repeat (n) tick();
    block_out_take = 1'b0;
  endtask

  // Stream n blocks with continuous take; blocks at positions in the message
  // that are multiples of mb (mb != 0) are expected to carry last.
  task automatic stream(input int n, input int mb, input logic [7:0] tag);
    block_in_ready = 1'b1;
    for (int k = 1; k <= n; k++) begin
      block_in = {tag, 120'(k)};
      expect_block(block_in, (mb != 0) && (k % mb == 0));
      tick();
      block_out_take = 1'b1;
    end
    block_in_ready = 1'b0;
    tick();
    block_out_take = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset          = 1'b1;
    block_in       = '0;
    block_in_ready = 1'b0;
    flush          = 1'b0;
    block_out_take = 1'b0;
    msg_blocks     = '0;

    // Monitor: compare every delivered block against the scoreboard head
    fork
      forever begin
        @(negedge clock);
        if (!reset && block_out_valid && block_out_take) begin
          check("sb_has_entry", BSIZE'(sb.size() != 0), BSIZE'(1));
          if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            check("pop_data", block_out, e.data);
            check("pop_last", BSIZE'(block_out_last), BSIZE'(e.last));
          end
        end
      end
    join_none

    // Reset values
    #1;
    check("rst_level", BSIZE'(level), 0);
    check("rst_valid", BSIZE'(block_out_valid), 0);
    check("rst_hold", BSIZE'(block_in_hold), 0);
    check("rst_block_out", block_out, 0);
    check("rst_last", BSIZE'(block_out_last), 0);
    check("rst_take_err", BSIZE'(take_err), 0);
    repeat (2) tick();
    reset = 1'b0;
    tick();

    // Single push with fall-through
    block_in = 128'h1;
    block_in_ready = 1'b1;
    expect_block(128'h1, 1'b0);
    tick();
    block_in_ready = 1'b0;
    check("ft_valid", BSIZE'(block_out_valid), 1);
    check("ft_data", block_out, 128'h1);
    check("ft_level", BSIZE'(level), 1);
    check("ft_hold", BSIZE'(block_in_hold), 0);
    drain(1);
    check("ft_drained", BSIZE'(level), 0);

    // Fill to full, hold off a fifth block, release with one take
    block_in_ready = 1'b1;
    block_in = BLK_A; expect_block(BLK_A, 1'b0); tick();
    block_in = BLK_B; expect_block(BLK_B, 1'b0); tick();
    block_in = BLK_C; expect_block(BLK_C, 1'b0); tick();
    block_in = BLK_D; expect_block(BLK_D, 1'b0); tick();
    check("full_level", BSIZE'(level), 4);
    check("full_hold", BSIZE'(block_in_hold), 1);
    block_in = BLK_E;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("held_level", BSIZE'(level), 4);
    end
    block_out_take = 1'b1;
    tick();
    block_out_take = 1'b0;
    check("after_take_level", BSIZE'(level), 3);
    check("after_take_hold", BSIZE'(block_in_hold), 0);
    expect_block(BLK_E, 1'b0);
    tick();
    block_in_ready = 1'b0;
    check("fifth_level", BSIZE'(level), 4);
    drain(4);
    check("full_drained", BSIZE'(level), 0);

    // Simultaneous push and pop at level 1
    block_in = BLK_X; block_in_ready = 1'b1;
    expect_block(BLK_X, 1'b0);
    tick();
    check("l1_level", BSIZE'(level), 1);
    block_in = BLK_Y; block_out_take = 1'b1;
    expect_block(BLK_Y, 1'b0);
    tick();
    block_in_ready = 1'b0; block_out_take = 1'b0;
    check("pp_level", BSIZE'(level), 1);
    check("pp_data", block_out, BLK_Y);
    drain(1);

    // Framing: restart the message counter, then 3-block messages
    flush = 1'b1; tick(); flush = 1'b0;
    msg_blocks = 16'd3;
    stream(7, 3, 8'hB0);
    check("frame_drained", BSIZE'(level), 0);
    msg_blocks = '0;
    stream(3, 0, 8'hC0);

    // Take while empty, sticky through flush
    block_out_take = 1'b1; tick(); block_out_take = 1'b0;
    check("empty_take_level", BSIZE'(level), 0);
    check("take_err_set", BSIZE'(take_err), 1);
    flush = 1'b1; tick(); flush = 1'b0;
    check("take_err_kept", BSIZE'(take_err), 1);

    // Flush with a concurrent push discards everything
    block_in_ready = 1'b1;
    block_in = BLK_A; tick();
    block_in = BLK_B; tick();
    check("prefl_level", BSIZE'(level), 2);
    block_in = BLK_C; flush = 1'b1;
    tick();
    flush = 1'b0; block_in_ready = 1'b0;
    check("fl_level", BSIZE'(level), 0);
    check("fl_valid", BSIZE'(block_out_valid), 0);
    check("fl_block_out", block_out, 0);
    tick();
    check("fl_level_stays", BSIZE'(level), 0);

    // Asynchronous reset mid-cycle with three blocks stored
    block_in_ready = 1'b1;
    block_in = BLK_C; tick();
    block_in = BLK_D; tick();
    block_in = BLK_E; tick();
    block_in_ready = 1'b0;
    check("prerst_level", BSIZE'(level), 3);
    #2 reset = 1'b1;
    #1;
    check("arst_valid", BSIZE'(block_out_valid), 0);
    check("arst_level", BSIZE'(level), 0);
    check("arst_hold", BSIZE'(block_in_hold), 0);
    check("arst_block_out", block_out, 0);
    check("arst_take_err", BSIZE'(take_err), 0);
    tick();
    reset = 1'b0;
    tick();
    check("post_rst_level", BSIZE'(level), 0);

    check("sb_empty_at_end", BSIZE'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
